gpu_cmd_tx: RTL and testbench

// - CPU-side transmitter for the GPU command bus (2-bit opcode, 8-bit data, 1-cycle enable strobe).
// - Takes whole commands over valid/ready. Splits each into one or more bus beats and drives the GPU inputs.
// - Sits between the CPU I/O decode and gpu. Its outputs connect directly to gpu interrupt_in/data_in/interrupt_enable.

---
 rtl/gpu_cmd_tx.sv | 171 +++++++++++++++++
 tb/tb_gpu_cmd_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_tx.sv
// rtl/gpu_cmd_tx.sv - GPU command bus transmitter: splits commands into opcode/data beats
// Optional command FIFO in front of the beat FSM, enabled by GPU_TX_CMD_FIFO_EN.
module gpu_cmd_tx #(
  parameter int GAP_CYCLES = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_byte,
  input  logic [9:0] cmd_x,
  input  logic [8:0] cmd_y,
  output logic [1:0] interrupt_out,
  output logic [7:0] data_out,
  output logic       interrupt_enable_out,
  output logic       busy
);
  localparam logic [1:0] OP_MOVE    = 2'b01;
  localparam logic [1:0] OP_DISPLAY = 2'b10;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BEAT, GAP} state_t;
  state_t state, state_nxt;

  logic       src_valid;
  logic [1:0] src_op;
  logic [7:0] src_byte;
  logic [9:0] src_x;
  logic [8:0] src_y;

  logic [9:0] xc;
  logic [8:0] yc;
  logic [7:0] nb0, nb1, nb2;
  logic [1:0] n_last;

  logic [7:0]    cur_b1, cur_b2;
  logic [1:0]    cur_last;
  logic [1:0]    beat_idx;
  logic [GW-1:0] gap_cnt;
  logic          beat_last, gap_last, load_cmd, next_beat;

  // Beat data for the command at the source, coordinates clamped to the screen
  always_comb begin
    xc     = (src_x > 10'd639) ? 10'd639 : src_x;
    yc     = (src_y > 9'd479) ? 9'd479 : src_y;
    nb0    = src_byte;
    nb1    = {yc[5:0], xc[9:8]};
    nb2    = {5'b0, yc[8:6]};
    n_last = 2'd0;
    case (src_op)
      OP_MOVE: begin
        nb0    = xc[7:0];
        n_last = 2'd2;
      end
      OP_DISPLAY: nb0 = 8'h00;
      default: ;
    endcase
  end

  assign beat_last = (beat_idx == cur_last);
  assign gap_last  = (gap_cnt == GAP_LAST);

  always_comb begin
    state_nxt = state;
    load_cmd  = 1'b0;
    next_beat = 1'b0;
    case (state)
      IDLE: begin
        if (src_valid) begin
          state_nxt = BEAT;
          load_cmd  = 1'b1;
        end
      end
      BEAT: begin
        if (GAP_CYCLES > 0) state_nxt = GAP;
        else if (!beat_last) next_beat = 1'b1;
        else if (src_valid) load_cmd = 1'b1;
        else state_nxt = IDLE;
      end
      GAP: begin
        if (gap_last) begin
          if (!beat_last) begin
            state_nxt = BEAT;
            next_beat = 1'b1;
          end else if (src_valid) begin
            state_nxt = BEAT;
            load_cmd  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are loaded only when a beat starts, so they hold through gaps and IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_b1        <= '0;
      cur_b2        <= '0;
      cur_last      <= '0;
      beat_idx      <= '0;
      gap_cnt       <= '0;
      interrupt_out <= '0;
      data_out      <= '0;
    end else begin
      state <= state_nxt;
      if (state == GAP) gap_cnt <= gap_cnt + 1'b1;
      else gap_cnt <= '0;
      if (load_cmd) begin
        cur_b1        <= nb1;
        cur_b2        <= nb2;
        cur_last      <= n_last;
        beat_idx      <= 2'd0;
        interrupt_out <= src_op;
        data_out      <= nb0;
      end else if (next_beat) begin
        beat_idx <= beat_idx + 2'd1;
        data_out <= (beat_idx == 2'd0) ? cur_b1 : cur_b2;
      end
    end
  end

  assign interrupt_enable_out = (state == BEAT);

`ifdef GPU_TX_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [28:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        full, empty, push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign cmd_ready = !rst && !full;
  assign push      = cmd_valid && cmd_ready;
  assign src_valid = !empty;
  assign {src_op, src_byte, src_x, src_y} = mem[rd_ptr[AW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_byte, cmd_x, cmd_y};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load_cmd) rd_ptr <= rd_ptr + 1'b1;
    end
  end
`else
  logic cmd_done;
  // Last cycle of the final beat (no gap) or of the final gap of the current command
  assign cmd_done  = ((state == BEAT) && beat_last && (GAP_CYCLES == 0)) ||
                     ((state == GAP) && gap_last && beat_last);
  assign cmd_ready = !rst && ((state == IDLE) || cmd_done);
  assign src_valid = cmd_valid;
  assign src_op    = cmd_op;
  assign src_byte  = cmd_byte;
  assign src_x     = cmd_x;
  assign src_y     = cmd_y;
  assign busy      = (state != IDLE);
`endif
endmodule

// File: tb/tb_gpu_cmd_tx.sv
// tb/tb_gpu_cmd_tx.sv - self-checking bench for gpu_cmd_tx (gap 1 and gap 0 instances)
module tb_gpu_cmd_tx;
  localparam int NI    = 2;
  localparam int GAP_A = 1;
  localparam int GAP_B = 0;
`ifdef GPU_TX_CMD_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    bit         cont;
    int         due;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v    [NI];
  logic       rdy  [NI];
  logic [1:0] op   [NI];
  logic [7:0] by   [NI];
  logic [9:0] cx   [NI];
  logic [8:0] cy   [NI];
  logic [1:0] iop  [NI];
  logic [7:0] dat  [NI];
  logic       en   [NI];
  logic       bsy  [NI];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc [NI];
  beat_t q0[$];
  beat_t q1[$];

  gpu_cmd_tx #(.GAP_CYCLES(GAP_A), .FIFO_DEPTH(4)) u_dut_a (
    .clk(clk), .rst(rst), .cmd_valid(v[0]), .cmd_ready(rdy[0]), .cmd_op(op[0]),
    .cmd_byte(by[0]), .cmd_x(cx[0]), .cmd_y(cy[0]), .interrupt_out(iop[0]),
    .data_out(dat[0]), .interrupt_enable_out(en[0]), .busy(bsy[0])
  );

  gpu_cmd_tx #(.GAP_CYCLES(GAP_B), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .cmd_valid(v[1]), .cmd_ready(rdy[1]), .cmd_op(op[1]),
    .cmd_byte(by[1]), .cmd_x(cx[1]), .cmd_y(cy[1]), .interrupt_out(iop[1]),
    .data_out(dat[1]), .interrupt_enable_out(en[1]), .busy(bsy[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int gap_of(input int i);
    return (i == 0) ? GAP_A : GAP_B;
  endfunction

  function automatic void put(input int s, input beat_t b);
    if (s == 0) q0.push_back(b);
    else q1.push_back(b);
  endfunction

  // Reference model: beats a command must produce, from the bus encoding rules
  function automatic void add_cmd(input int s, input logic [1:0] o, input logic [7:0] b8,
                                  input logic [9:0] x, input logic [8:0] y, input int acc);
    int xc, yc;
    beat_t b;
    xc = (int'(x) > 639) ? 639 : int'(x);
    yc = (int'(y) > 479) ? 479 : int'(y);
    b.op = o;
    b.cont = 1'b0;
    b.due = (LAT == 1) ? acc : -1;
    if (o == 2'd1) begin
      b.data = 8'(xc % 256);
      put(s, b);
      b.cont = 1'b1;
      b.due = -1;
      b.data = 8'((yc % 64) * 4 + xc / 256);
      put(s, b);
      b.data = 8'(yc / 64);
      put(s, b);
    end else begin
      b.data = (o == 2'd2) ? 8'h00 : b8;
      put(s, b);
    end
  endfunction

  task automatic check_strobe(input int i);
    beat_t b;
    bit have;
    have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
    chk($sformatf("strobe_expected_%0d", i), 32'(have), 32'd1);
    if (have) begin
      b = (i == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("beat_op_%0d", i), 32'(iop[i]), 32'(b.op));
      chk($sformatf("beat_data_%0d", i), 32'(dat[i]), 32'(b.data));
      if (b.cont) chk($sformatf("beat_spacing_%0d", i), 32'(cyc - last_cyc[i]), 32'(gap_of(i) + 1));
      else if (b.due >= 0) chk($sformatf("first_beat_latency_%0d", i), 32'(cyc), 32'(b.due));
    end
    last_cyc[i] = cyc;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) if (en[i]) check_strobe(i);
    end
  end

  task automatic send(input int s, input logic [1:0] o, input logic [7:0] b8,
                      input logic [9:0] x, input logic [8:0] y, output int acc);
    int n;
    n = 0;
    acc = -1;
    v[s] = 1'b1; op[s] = o; by[s] = b8; cx[s] = x; cy[s] = y;
    while (!rdy[s] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_timeout", 32'(n < 200), 32'd1);
    if (rdy[s]) begin
      @(posedge clk); #1;
      acc = cyc;
      add_cmd(s, o, b8, x, y, acc);
    end
    v[s] = 1'b0;
    op[s] = 2'($urandom); by[s] = 8'($urandom); cx[s] = 10'($urandom); cy[s] = 9'($urandom);
  endtask

  task automatic drain(input int s);
    int n;
    n = 0;
    while ((bsy[s] || ((s == 0) ? q0.size() : q1.size()) != 0) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("drain_%0d", s), 32'(n < 500), 32'd1);
  endtask

  initial begin
    int acc, acc2, n;
    for (int i = 0; i < NI; i++) begin
      v[i] = 1'b1; op[i] = 2'd0; by[i] = 8'h00; cx[i] = '0; cy[i] = '0; last_cyc[i] = 0;
    end
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", 32'(rdy[i]), 0);
      chk("reset_iop", 32'(iop[i]), 0);
      chk("reset_data", 32'(dat[i]), 0);
      chk("reset_strobe", 32'(en[i]), 0);
      chk("reset_busy", 32'(bsy[i]), 0);
      v[i] = 1'b0;
    end
    rst = 1'b0;
    @(posedge clk); #1;

    send(0, 2'd0, 8'hA5, 10'd0, 9'd0, acc);
`ifndef GPU_TX_CMD_FIFO_EN
    chk("store_strobe", 32'(en[0]), 1);
    chk("store_busy_beat", 32'(bsy[0]), 1);
    @(posedge clk); #1;
    chk("store_strobe_gap", 32'(en[0]), 0);
    chk("store_busy_gap", 32'(bsy[0]), 1);
    @(posedge clk); #1;
    chk("store_busy_done", 32'(bsy[0]), 0);
`endif
    drain(0);
    chk("store_hold_op", 32'(iop[0]), 32'h0);
    chk("store_hold_data", 32'(dat[0]), 32'hA5);

    send(0, 2'd1, 8'h00, 10'd515, 9'd301, acc);
    drain(0);
    chk("move_op", 32'(iop[0]), 32'h1);
    chk("move_last_data", 32'(dat[0]), 32'h04);

    send(0, 2'd1, 8'h00, 10'd1000, 9'd500, acc);
    drain(0);
    chk("move_clamp_last", 32'(dat[0]), 32'h07);

    send(1, 2'd2, 8'h55, 10'd0, 9'd0, acc);
    send(1, 2'd3, 8'h1F, 10'd0, 9'd0, acc2);
`ifndef GPU_TX_CMD_FIFO_EN
    chk("b2b_accept_gap", 32'(acc2 - acc), 1);
`endif
    drain(1);
    chk("clear_op", 32'(iop[1]), 32'h3);
    chk("clear_data", 32'(dat[1]), 32'h1F);

    // Reset after the first beat of a MOVE_CURSOR
    send(0, 2'd1, 8'h00, 10'($urandom), 9'($urandom), acc);
    n = 0;
    while (!en[0] && n < 10) begin @(posedge clk); #1; n++; end
    chk("mid_reset_first_beat", 32'(en[0]), 1);
    @(negedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_reset_strobe", 32'(en[0]), 0);
    chk("mid_reset_iop", 32'(iop[0]), 0);
    chk("mid_reset_data", 32'(dat[0]), 0);
    chk("mid_reset_busy", 32'(bsy[0]), 0);
    chk("mid_reset_ready", 32'(rdy[0]), 0);
    q0.delete();
    rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    chk("post_reset_busy", 32'(bsy[0]), 0);

`ifdef GPU_TX_CMD_FIFO_EN
    send(0, 2'd1, 8'h00, 10'd5, 9'd5, acc);
    for (int i = 0; i < 5; i++) begin
      chk("fifo_ready", 32'(rdy[0]), 32'(i < 4));
      send(0, 2'd0, 8'(8'h10 + i), 10'd0, 9'd0, acc);
    end
    drain(0);
`endif

    for (int s = 0; s < NI; s++) begin
      for (int k = 0; k < 25; k++) begin
        send(s, 2'($urandom), 8'($urandom), 10'($urandom), 9'($urandom), acc);
        repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      end
      drain(s);
    end

    chk("queue_a_empty", 32'(q0.size()), 0);
    chk("queue_b_empty", 32'(q1.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
